fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
// - Drains the shift FIFO (show-ahead: dataout valid whenever val=1, pop on read) and serialises each word as a UART frame.
// - Sits directly downstream of fifo_sh and drives its read strobe.
// - Pops a word only when it is idle, or on the last cycle of a frame, so back-to-back words leave with no idle gap.
// PARAMETERS
// - DATA_WIDTH  8   word width, equal to the FIFO DATA_WIDTH
// - CLK_DIV     16  clk cycles per bit; must be >= 2
// - PARITY_EN   0   1 = insert a parity bit after the data bits
// - PARITY_ODD  0   parity sense: 0 = even, 1 = odd; ignored when PARITY_EN=0
// - STOP_BITS   1   number of stop bits, 1 or 2
// PORTS
// - clk         in   1           single clock; all state updates on posedge
// - reset       in   1           synchronous, active-high
// - fifo_data   in   DATA_WIDTH  FIFO head word (dataout)
// - fifo_val    in   1           FIFO non-empty (val)
// - fifo_read   out  1           pop strobe to the FIFO; combinational, one cycle per word
// - enable      in   1           permit fetching new words
// - tx          out  1           serial line, idles high; registered
// - busy        out  1           a frame is in progress; registered
// - frame_done  out  1           one-cycle pulse on the last cycle of each frame
// BEHAVIOUR
// - Reset values: tx=1, busy=0, frame_done=0, state=IDLE, baud count=0, bit index=0.
//   fifo_read is gated by !reset, so it is 0 while reset is high.
// - FSM states: IDLE, START, DATA, PARITY, STOP. Every bit period lasts exactly CLK_DIV cycles.
//   The baud counter counts 0..CLK_DIV-1; "tick" is its terminal count.
// - Fetch: fetch = enable & fifo_val & (state==IDLE | (state==STOP & tick & last stop bit)); fifo_read = fetch.
//   In the same cycle: shift reg <= fifo_data, parity <= ^fifo_data ^ PARITY_ODD, baud count <= 0, bit index <= 0, state <= START.
// - Latency: tx falls 1 cycle after the fetch cycle.
// - START: tx=0 for one bit period; on tick -> DATA.
// - DATA: tx = shift reg bit 0 (LSB first). On each tick: shift right, increment bit index.
//   After DATA_WIDTH bits -> PARITY if PARITY_EN=1, else -> STOP.
// - PARITY: tx = stored parity bit for one bit period; on tick -> STOP.
// - STOP: tx=1 for STOP_BITS bit periods. On the final tick: frame_done=1 that cycle; then fetch again if possible, else -> IDLE.
// - Frame length: CLK_DIV*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles, with zero gap between back-to-back frames.
// - busy=1 from the cycle after fetch until the end of the frame; in IDLE busy=0 and tx=1.
// - enable dropping mid-frame: the current frame completes unchanged; no further fetch until enable returns.
// - FIFO empty (fifo_val=0) at the frame end: return to IDLE. A word arriving later is fetched in the first IDLE cycle where fifo_val=1.
// - FIFO full: nothing special; popping is the only interaction.
// - fifo_read is never asserted when fifo_val=0, and never more than once per frame.
// - Reset mid-frame: next cycle tx=1, busy=0, FSM in IDLE. The partially sent word is dropped; the FIFO is not popped again for it.
// - Counter widths: baud counter $clog2(CLK_DIV); bit index $clog2(DATA_WIDTH+1). Neither wraps beyond its terminal count.
// STRUCTURE
// - Package fifo_uart_pkg: state encodings (localparam 3-bit IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and a frame-length function.
// - Sub-module uart_baud_gen: CLK_DIV counter with sync clear (on fetch) and a tick output.
//   The FSM, shift register and parity logic stay in fifo_uart_tx.
// TESTING
// - Benches instantiate fifo_sh(DEPTH=4) feeding the DUT; defaults with CLK_DIV=4.
// - Test 1: reset held 3 cycles with FIFO preloaded
//   -> fifo_read=0, tx=1, busy=0 throughout; first fetch in the cycle after reset falls.
// - Test 2: single word 8'hA5 pushed, enable=1
//   -> fifo_read pulses once; tx sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 4 cycles;
//      frame_done 40 cycles after fetch; val=0 afterwards.
// - Test 3: words 8'h01, 8'h80, 8'hFF pushed back-to-back
//   -> three frames with no idle bit between them; fifo_read pulses exactly on each frame's last cycle; busy stays 1 for 120 cycles.
// - Test 4: PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, word 8'h03
//   -> parity bit=1, two stop bits, frame 48 cycles long.
// - Test 5: enable dropped during the DATA bits of word 1 while the FIFO holds word 2
//   -> word 1 completes; DUT goes IDLE and word 2 stays in the FIFO; enable=1 -> word 2 is fetched next cycle.
// - Test 6: reset asserted in the middle of the DATA state
//   -> next cycle tx=1, busy=0; no frame_done pulse; no extra pop; FIFO count unchanged by the reset.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding and frame sizing.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  // Clock cycles occupied by one complete frame.
  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input int unsigned clk_div,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return clk_div * (1 + data_width + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 while running, flags the terminal count and the cycle
// before it.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick     = (cnt_q == CntW'(CLK_DIV - 1));
  assign pre_tick = (cnt_q == CntW'(CLK_DIV - 2));

  always_ff @(posedge clk) begin
    if (reset || clear || !run) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls words from a show-ahead FIFO and serialises each as a UART frame, refetching on the
// last stop-bit cycle so consecutive frames leave with no idle gap.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_val,
  output logic                  fifo_read,
  input  logic                  enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  parity_q;
  logic [IdxW-1:0]       idx_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  frame_done_q;

  logic tick;
  logic pre_tick;
  logic last_data;
  logic last_stop;
  logic fetch;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (fetch),
    .run     (state_q != StIdle),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  assign shift_nxt = shift_q >> 1;
  assign last_data = (idx_q == IdxW'(DATA_WIDTH - 1));
  // In STOP the bit index counts stop bits rather than data bits.
  assign last_stop = (idx_q == IdxW'(STOP_BITS - 1));

  assign fetch = !reset && enable && fifo_val &&
                 ((state_q == StIdle) || ((state_q == StStop) && tick && last_stop));

  assign fifo_read  = fetch;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      idx_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // Registered one cycle early so the pulse lands on the frame's final cycle.
      frame_done_q <= (state_q == StStop) && pre_tick && last_stop;
      if (fetch) begin
        shift_q  <= fifo_data;
        parity_q <= (^fifo_data) ^ (PARITY_ODD != 0);
        idx_q    <= '0;
        state_q  <= StStart;
        tx_q     <= 1'b0;
        busy_q   <= 1'b1;
      end else if (tick) begin
        unique case (state_q)
          StStart: begin
            state_q <= StData;
            tx_q    <= shift_q[0];
          end
          StData: begin
            shift_q <= shift_nxt;
            if (last_data) begin
              idx_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= StParity;
                tx_q    <= parity_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + IdxW'(1);
              tx_q  <= shift_nxt[0];
            end
          end
          StParity: begin
            state_q <= StStop;
            idx_q   <= '0;
            tx_q    <= 1'b1;
          end
          StStop: begin
            if (last_stop) begin
              state_q <= StIdle;
              idx_q   <= '0;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
